// File: rtl/zxuno_regport.sv
// rtl/zxuno_regport.sv - Z80-facing register-select/data port front end for the ZXUNO register space
//
// Decodes Z80 I/O cycles on the register-select port and the register data port.
// Latches the selected register number and generates the strobe bus that every
// register block consumes. Returns register read data to the CPU bus.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   a                CPU address bus (full 16-bit I/O decode)
//   iorq_n, rd_n,    CPU I/O request and read/write strobes, active low
//   wr_n
//   din              CPU write data
//   reg_din, reg_oe  OR-combined read data from register blocks and its valid flag
//   zxuno_addr       currently selected register number
//   zxuno_regrd      level, high while a data-port read cycle is in progress
//   zxuno_regwr      one-clock pulse per data-port write
//   zxuno_dout       captured write data, valid while zxuno_regwr is high
//   regaddr_changed  one-clock pulse per register-select write
//   dout, oe         read data to the CPU and its bus-drive enable

module zxuno_regport #(
   parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
   parameter logic [15:0] DATA_PORT  = 16'hFD3B,
   parameter logic [7:0]  RESET_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic [7:0]  din,
   input  logic [7:0]  reg_din,
   input  logic        reg_oe,
   output logic [7:0]  zxuno_addr,
   output logic        zxuno_regrd,
   output logic        zxuno_regwr,
   output logic [7:0]  zxuno_dout,
   output logic        regaddr_changed,
   output logic [7:0]  dout,
   output logic        oe
);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      WR_ACTIVE = 2'd2,
      RD_ACTIVE = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nx;
   logic       r_on_data;      // active write cycle targets the data port
   logic       w_on_data_nx;
   logic [7:0] w_addr_nx;
   logic [7:0] w_dout_nx;
   logic       w_regwr_nx;
   logic       w_regrd_nx;
   logic       w_chg_nx;

   logic       w_hit_a;
   logic       w_hit_d;
   logic       w_wr;
   logic       w_rd;
   logic       w_wr_still;

   assign w_hit_a = (a == ADDR_PORT) && !iorq_n;
   assign w_hit_d = (a == DATA_PORT) && !iorq_n;
   // A cycle showing both strobes is taken as a write.
   assign w_wr    = !wr_n;
   assign w_rd    = !rd_n && wr_n;

   // The write cycle continues only while the address stays on the port it started on;
   // the address moving away counts as the end of the cycle.
   assign w_wr_still = (r_on_data ? w_hit_d : w_hit_a) && w_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= WAIT_IDLE;
         r_on_data       <= 1'b0;
         zxuno_addr      <= RESET_ADDR;
         zxuno_dout      <= 8'h00;
         zxuno_regwr     <= 1'b0;
         zxuno_regrd     <= 1'b0;
         regaddr_changed <= 1'b0;
      end else begin
         r_state         <= w_state_nx;
         r_on_data       <= w_on_data_nx;
         zxuno_addr      <= w_addr_nx;
         zxuno_dout      <= w_dout_nx;
         zxuno_regwr     <= w_regwr_nx;
         zxuno_regrd     <= w_regrd_nx;
         regaddr_changed <= w_chg_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_on_data_nx = r_on_data;
      w_addr_nx    = zxuno_addr;
      w_dout_nx    = zxuno_dout;
      w_regwr_nx   = 1'b0;
      w_regrd_nx   = 1'b0;
      w_chg_nx     = 1'b0;

      unique case (r_state)
         // Wait for the bus to go quiet so a reset taken mid-cycle never yields a strobe.
         WAIT_IDLE: begin
            if (iorq_n) begin
               w_state_nx = IDLE;
            end
         end

         IDLE: begin
            if (w_hit_a && w_wr) begin
               // Pulses even when din matches the current address; consumers restart on it.
               w_addr_nx    = din;
               w_chg_nx     = 1'b1;
               w_on_data_nx = 1'b0;
               w_state_nx   = WR_ACTIVE;
            end else if (w_hit_d && w_wr) begin
               w_dout_nx    = din;
               w_regwr_nx   = 1'b1;
               w_on_data_nx = 1'b1;
               w_state_nx   = WR_ACTIVE;
            end else if (w_hit_d && w_rd) begin
               w_regrd_nx   = 1'b1;
               w_state_nx   = RD_ACTIVE;
            end
         end

         // One pulse per write regardless of how long the strobe is held.
         WR_ACTIVE: begin
            if (!w_wr_still) begin
               w_state_nx = IDLE;
            end
         end

         // zxuno_regrd falls on the cycle end; consumers advance read pointers on that edge.
         RD_ACTIVE: begin
            if (w_hit_d && !rd_n) begin
               w_regrd_nx = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end

         default: begin
            w_state_nx = WAIT_IDLE;
         end
      endcase
   end

   // Zero-latency read return.
   always_comb begin
      oe   = 1'b0;
      dout = 8'hFF;
      if (w_hit_a && w_rd) begin
         oe   = 1'b1;
         dout = zxuno_addr;
      end else if (w_hit_d && w_rd) begin
         oe   = 1'b1;
         dout = reg_oe ? reg_din : 8'hFF;
      end
   end

endmodule
